seg_scan_drv: RTL and testbench
===============================

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter N_DIG, default 8, SHALL set the number of digits; the legal range is 1..16.
REQ-003 Parameter DIV, default 1000, SHALL set the number of clk cycles per digit slot; DIV SHALL be at least 2.
REQ-004 Parameter GUARD, default 8, SHALL set the anti-ghost blank cycles at the start of each slot; GUARD SHALL be less than DIV (0 is allowed).
REQ-005 Parameter SEG_ACT_LOW, default 0, SHALL select segment polarity: 1 means a lit segment is driven 0.
REQ-006 Parameter COM_ACT_LOW, default 1, SHALL select common polarity: 1 means the selected digit is driven 0.
REQ-007 clk  input  1  system clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 din  input  4*N_DIG  hex nibbles; nibble i = din[4i+3:4i]; digit 0 is least significant.
REQ-010 dp_in  input  N_DIG  decimal point request per digit.
REQ-011 blank  input  N_DIG  per-digit forced blank.
REQ-012 lz_en  input  1  leading-zero suppression enable; used live, not shadowed.
REQ-013 load  input  1  shadow-capture strobe.
REQ-014 seg_d  output  8  segments {dp,g,f,e,d,c,b,a}; registered.
REQ-015 com  output  N_DIG  digit commons; one-hot active or all inactive; registered.
REQ-016 frame_tick  output  1  one-cycle pulse at end of a full scan; registered.

Function
REQ-017 The decode (active-high, dp excluded) SHALL be: 0:3f 1:06 2:5b 3:4f 4:66 5:6d 6:7d 7:27 8:7f 9:6f a:5f b:7c c:58 d:5e e:7b f:71.
REQ-018 When load=1 at an edge, the shadow registers SHALL capture din, dp_in and blank; the display SHALL use only the shadow values, and the captured values SHALL first appear on the outputs at the following edge.
REQ-019 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; at wrap, idx SHALL advance by one, and from N_DIG-1 it SHALL go to 0.
REQ-020 frame_tick SHALL be 1 for exactly one cycle, registered, on the cycle after cnt=DIV-1 with idx=N_DIG-1.
REQ-021 While cnt<GUARD, com SHALL be all inactive and seg_d SHALL be all unlit.
REQ-022 Otherwise, com[idx] SHALL be active and all other com bits inactive; seg_d SHALL show {dp_shadow[idx], decode(nibble idx)}.
REQ-023 If blank_shadow[idx]=1, seg_d SHALL be all unlit (including dp) and com SHALL be all inactive for the whole slot.
REQ-024 When lz_en=1, digit i with i>=1 SHALL be suppressed if nibble i and all higher nibbles are 0; a suppressed digit SHALL light only dp, if dp is set.
REQ-025 Digit 0 SHALL never be suppressed.
REQ-026 SEG_ACT_LOW and COM_ACT_LOW SHALL invert the final registered values only.
REQ-027 Both the segment output and the common output SHALL have one cycle of latency from the cnt/idx state to the pins.
REQ-028 A load arriving during any slot SHALL NOT reset cnt or idx; the new data SHALL appear mid-slot.
REQ-029 N_DIG=1 SHALL work: idx is constant 0, and frame_tick pulses every DIV cycles.

Reset
REQ-030 While rst_n=0, asynchronously: cnt=0, idx=0, shadow din=0, shadow dp=0, shadow blank all 1s.
REQ-031 While rst_n=0, seg_d and com SHALL be at their inactive levels (per polarity) and frame_tick=0.
REQ-032 After release, scanning SHALL start at digit 0 with cnt=0, and the display SHALL stay dark until the first load.
REQ-033 Asserting rst_n mid-scan SHALL return the block to the reset state immediately.

Verification (N_DIG=4, DIV=4, GUARD=1, SEG_ACT_LOW=0, COM_ACT_LOW=1)
REQ-034 Basic scan: load din=16'h1234, dp=0, blank=0 -> each digit i shows com=~(1<<i); digit0 shows seg_d=66, digit1=4f, digit2=5b, digit3=06; com=4'hf for 1 of every 4 cycles.
REQ-035 Decode: load each value 0..f on digit 0 in turn -> seg_d matches REQ-017 for every value, including 7:27 and f:71.
REQ-036 Leading zeros: din=16'h0050, lz_en=1, dp_in=4'b1000 -> digit3 seg_d=80, digit2 dark, digit1=6d, digit0=3f; with lz_en=0, digit2=3f and digit3=bf.
REQ-037 Blank and frame: blank=4'b0100 -> com stays 4'hf through digit2's slot; frame_tick pulses once every 16 cycles.
REQ-038 Reset and load timing: rst_n pulsed low mid-slot -> seg_d=00 and com=f at once; after release, dark until load; a load in mid-slot changes seg_d on the next edge while cnt continues.

Source files
------------

// File: rtl/seg_scan_drv.sv
// Multiplexed seven-segment scan driver: shadowed hex data, per-digit blank/dp,
// live leading-zero suppression, anti-ghost guard band and registered pins.
module seg_scan_drv #(
    parameter int N_DIG       = 8,
    parameter int DIV         = 1000,
    parameter int GUARD       = 8,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit COM_ACT_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*N_DIG-1:0]   din,
    input  logic [N_DIG-1:0]     dp_in,
    input  logic [N_DIG-1:0]     blank,
    input  logic                 lz_en,
    input  logic                 load,
    output logic [7:0]           seg_d,
    output logic [N_DIG-1:0]     com,
    output logic                 frame_tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    // XOR masks that turn active-high "lit"/"selected" into pin levels.
    localparam logic [7:0]       SEG_OFF = SEG_ACT_LOW ? 8'hff : 8'h00;
    localparam logic [N_DIG-1:0] COM_OFF = COM_ACT_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [4*N_DIG-1:0] din_sh;
    logic [N_DIG-1:0]   dp_sh;
    logic [N_DIG-1:0]   blank_sh;

    logic               cnt_wrap;
    logic               idx_last;
    logic               in_guard;
    logic               suppress;
    logic [3:0]         nib;
    logic [N_DIG-1:0]   zero_above;
    logic [7:0]         lit_seg;
    logic [N_DIG-1:0]   lit_com;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3f;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5b;
            4'h3: decode = 7'h4f;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6d;
            4'h6: decode = 7'h7d;
            4'h7: decode = 7'h27;
            4'h8: decode = 7'h7f;
            4'h9: decode = 7'h6f;
            4'ha: decode = 7'h5f;
            4'hb: decode = 7'h7c;
            4'hc: decode = 7'h58;
            4'hd: decode = 7'h5e;
            4'he: decode = 7'h7b;
            default: decode = 7'h71;
        endcase
    endfunction

    // Shadow registers reset to all-blank so the display stays dark until the first load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sh   <= '0;
            dp_sh    <= '0;
            blank_sh <= '1;
        end else if (load) begin
            din_sh   <= din;
            dp_sh    <= dp_in;
            blank_sh <= blank;
        end
    end

    assign cnt_wrap = (cnt == CNT_W'(DIV - 1));
    assign idx_last = (idx == IDX_W'(N_DIG - 1));

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            idx <= idx_last ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        lit_seg  = '0;
        lit_com  = '0;
        nib      = din_sh[4*idx +: 4];
        in_guard = (GUARD > 0) && (cnt < CNT_W'(GUARD));

        // zero_above[i]: nibble i and every higher nibble are zero.
        zero_above = '0;
        begin : zscan
            logic acc;
            acc = 1'b1;
            for (int i = N_DIG - 1; i >= 0; i--) begin
                acc           = acc & (din_sh[4*i +: 4] == 4'h0);
                zero_above[i] = acc;
            end
        end

        suppress = lz_en && (idx != '0) && zero_above[idx];

        if (!in_guard && !blank_sh[idx]) begin
            lit_com[idx] = 1'b1;
            lit_seg      = suppress ? {dp_sh[idx], 7'h00} : {dp_sh[idx], decode(nib)};
        end
    end

    // Pins are registered at their physical polarity so reset drives them straight to inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_d      <= SEG_OFF;
            com        <= COM_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg_d      <= lit_seg ^ SEG_OFF;
            com        <= lit_com ^ COM_OFF;
            frame_tick <= cnt_wrap && idx_last;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv (N_DIG=4, DIV=4, GUARD=1, active-high segments, active-low commons).
module tb_seg_scan_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_en;
    logic        load;
    logic [7:0]  seg_d;
    logic [3:0]  com;
    logic        frame_tick;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;   // edges since reset release; outputs after edge k reflect scan step k-1

    logic [7:0] dec_tab [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h27,
                                 8'h7f, 8'h6f, 8'h5f, 8'h7c, 8'h58, 8'h5e, 8'h7b, 8'h71};

    seg_scan_drv #(
        .N_DIG(4), .DIV(4), .GUARD(1), .SEG_ACT_LOW(1'b0), .COM_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .blank(blank),
        .lz_en(lz_en), .load(load), .seg_d(seg_d), .com(com), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Advance at least one edge, until the outputs show digit d at prescaler value c.
    task automatic goto_slot(input int d, input int c);
        do step(1);
        while (!((((cyc - 1) % 4) == c) && ((((cyc - 1) / 4) % 4) == d)));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        din   = d;
        dp_in = dp;
        blank = bl;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    initial begin
        int ft_bad;
        int ft_cnt;
        rst_n = 1'b0;
        din   = '0;
        dp_in = '0;
        blank = '0;
        lz_en = 1'b0;
        load  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", 16'(seg_d), 16'h00);
        check("rst_com", 16'(com), 16'hf);
        check("rst_ft", 16'(frame_tick), 16'h0);
        rst_n = 1'b1;
        cyc   = 0;

        // Dark until first load
        goto_slot(1, 2);
        check("dark_seg", 16'(seg_d), 16'h00);
        check("dark_com", 16'(com), 16'hf);

        // Basic scan of 1234
        do_load(16'h1234, 4'b0000, 4'b0000);
        goto_slot(0, 2);
        check("d0_seg", 16'(seg_d), 16'h66);
        check("d0_com", 16'(com), 16'he);
        goto_slot(1, 1);
        check("d1_seg", 16'(seg_d), 16'h4f);
        check("d1_com", 16'(com), 16'hd);
        goto_slot(2, 3);
        check("d2_seg", 16'(seg_d), 16'h5b);
        check("d2_com", 16'(com), 16'hb);
        goto_slot(3, 1);
        check("d3_seg", 16'(seg_d), 16'h06);
        check("d3_com", 16'(com), 16'h7);
        goto_slot(0, 0);
        check("guard_com", 16'(com), 16'hf);
        check("guard_seg", 16'(seg_d), 16'h00);

        // Full decode table on digit 0
        for (int v = 0; v < 16; v++) begin
            do_load(16'(v), 4'b0000, 4'b0000);
            goto_slot(0, 1);
            check($sformatf("dec_%h", v), 16'(seg_d), 16'(dec_tab[v]));
        end

        // Leading-zero suppression, lz_en used live
        lz_en = 1'b1;
        do_load(16'h0050, 4'b1000, 4'b0000);
        goto_slot(0, 1);
        check("lz_d0", 16'(seg_d), 16'h3f);
        goto_slot(1, 1);
        check("lz_d1", 16'(seg_d), 16'h6d);
        goto_slot(2, 1);
        check("lz_d2", 16'(seg_d), 16'h00);
        goto_slot(3, 1);
        check("lz_d3", 16'(seg_d), 16'h80);
        lz_en = 1'b0;
        goto_slot(2, 2);
        check("nolz_d2", 16'(seg_d), 16'h3f);
        goto_slot(3, 2);
        check("nolz_d3", 16'(seg_d), 16'hbf);

        // Per-digit blank
        do_load(16'h1234, 4'b0000, 4'b0100);
        goto_slot(1, 3);
        check("bl_d1_seg", 16'(seg_d), 16'h4f);
        for (int c = 0; c < 4; c++) begin
            goto_slot(2, c);
            check($sformatf("bl_d2_com_c%0d", c), 16'(com), 16'hf);
            check($sformatf("bl_d2_seg_c%0d", c), 16'(seg_d), 16'h00);
        end
        goto_slot(3, 1);
        check("bl_d3_seg", 16'(seg_d), 16'h06);

        // frame_tick: one pulse per 16 cycles, right after the last step of the frame
        ft_bad = 0;
        ft_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            step(1);
            if (frame_tick) ft_cnt++;
            if (frame_tick !== (((cyc - 1) % 16) == 15)) ft_bad++;
        end
        check("ft_count", 16'(ft_cnt), 16'd2);
        check("ft_position", 16'(ft_bad), 16'd0);

        // Asynchronous mid-slot reset
        do_load(16'h1234, 4'b0000, 4'b0000);
        goto_slot(1, 2);
        check("pre_rst_seg", 16'(seg_d), 16'h4f);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", 16'(seg_d), 16'h00);
        check("async_rst_com", 16'(com), 16'hf);
        check("async_rst_ft", 16'(frame_tick), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        goto_slot(0, 2);
        check("post_rst_dark_seg", 16'(seg_d), 16'h00);
        check("post_rst_dark_com", 16'(com), 16'hf);

        // Mid-slot load: new data on the following edge, scan continues undisturbed
        goto_slot(1, 1);
        do_load(16'h1234, 4'b0000, 4'b0000);
        check("midload_capture_edge", 16'(seg_d), 16'h00);
        step(1);
        check("midload_seg", 16'(seg_d), 16'h4f);
        check("midload_com", 16'(com), 16'hd);
        step(1);
        check("midload_next_guard", 16'(com), 16'hf);
        step(1);
        check("midload_next_d2", 16'(seg_d), 16'h5b);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
